// File: rtl/lap_stopwatch.sv
// Lap stopwatch: hundredths/sec/min/hour counter with saturation,
// synchronised start/stop and reset/lap buttons, and a lap-capture FIFO.
// Ports: clock, reset (async, active-low), rezhim, button_start_stop,
//   button_reset, lap_rd in; running, data_s, lap_data, lap_valid,
//   lap_count, lap_overflow, overflow out.
module lap_stopwatch #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HOUR_MAX  = 99,
  parameter int LAP_DEPTH = 4,
  parameter int MODE_ID   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     rezhim,
  input  logic                           button_start_stop,
  input  logic                           button_reset,
  input  logic                           lap_rd,
  output logic                           running,
  output logic [31:0]                    data_s,
  output logic [31:0]                    lap_data,
  output logic                           lap_valid,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_overflow,
  output logic                           overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int AW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW  = $clog2(LAP_DEPTH + 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ss_sync_q, rs_sync_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      csec_q, csec_d;
  logic [7:0]      sec_q, sec_d;
  logic [7:0]      min_q, min_d;
  logic [7:0]      hour_q, hour_d;
  logic            ov_q, ov_d;
  logic            lov_q, lov_d;
  logic [31:0]     mem_q [LAP_DEPTH];
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic mode_ok, ss_p, rs_p;
  logic clr, lap, tick, at_max;
  logic full, do_pop, do_push;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(LAP_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // sync bits: [0] first stage, [1] second stage, [2] previous value
  assign mode_ok = (rezhim == 2'(MODE_ID));
  assign ss_p    = ss_sync_q[1] & ~ss_sync_q[2] & mode_ok;
  assign rs_p    = rs_sync_q[1] & ~rs_sync_q[2] & mode_ok;

  assign running      = (state_q == ST_RUN);
  assign data_s       = {hour_q, min_q, sec_q, csec_q};
  assign lap_valid    = (cnt_q != '0);
  assign lap_count    = cnt_q;
  assign lap_data     = lap_valid ? mem_q[rd_q] : '0;
  assign lap_overflow = lov_q;
  assign overflow     = ov_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    csec_d  = csec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    ov_d    = ov_q;
    lov_d   = lov_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    clr    = rs_p && (state_q == ST_STOP);
    lap    = rs_p && (state_q == ST_RUN);
    tick   = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
    at_max = (csec_q == 8'd99) && (sec_q == 8'd59) &&
             (min_q == 8'd59) && (hour_q == 8'(HOUR_MAX));

    full    = (cnt_q == CW'(LAP_DEPTH));
    do_pop  = lap_rd && (cnt_q != '0);
    // a pop in the same cycle frees the slot for a lap on a full FIFO
    do_push = lap && (!full || do_pop);

    if (state_q == ST_RUN)
      presc_d = tick ? '0 : presc_q + PW'(1);

    if (tick && !at_max) begin
      if (csec_q == 8'd99) begin
        csec_d = '0;
        if (sec_q == 8'd59) begin
          sec_d = '0;
          if (min_q == 8'd59) begin
            min_d  = '0;
            hour_d = hour_q + 8'd1;
          end else begin
            min_d = min_q + 8'd1;
          end
        end else begin
          sec_d = sec_q + 8'd1;
        end
      end else begin
        csec_d = csec_q + 8'd1;
      end
    end

    if (tick && at_max) begin
      ov_d    = 1'b1;
      state_d = ST_STOP;
    end

    // start is locked out after saturation until a clear
    if (ss_p) begin
      if (state_q == ST_RUN)
        state_d = ST_STOP;
      else if (!ov_q)
        state_d = ST_RUN;
    end

    if (lap && full && !do_pop)
      lov_d = 1'b1;

    if (do_pop)
      rd_d = nxt(rd_q);
    if (do_push)
      wr_d = nxt(wr_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);

    if (clr) begin
      presc_d = '0;
      csec_d  = '0;
      sec_d   = '0;
      min_d   = '0;
      hour_d  = '0;
      ov_d    = 1'b0;
      lov_d   = 1'b0;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOP;
      ss_sync_q <= '0;
      rs_sync_q <= '0;
      presc_q   <= '0;
      csec_q    <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      ov_q      <= 1'b0;
      lov_q     <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < LAP_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ss_sync_q <= {ss_sync_q[1:0], button_start_stop};
      rs_sync_q <= {rs_sync_q[1:0], button_reset};
      presc_q   <= presc_d;
      csec_q    <= csec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      ov_q      <= ov_d;
      lov_q     <= lov_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      if (do_push)
        mem_q[wr_q] <= data_s;
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: directed scenarios plus random button/pop
// traffic, checked against a time-in-hundredths reference model.
module tb_lap_stopwatch;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int HOUR_MAX  = 1;
  localparam int LAP_DEPTH = 2;
  localparam int MODE_ID   = 2;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int CW        = $clog2(LAP_DEPTH + 1);
  localparam int MAXT      = (HOUR_MAX * 3600 + 3599) * 100 + 99;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    rezhim = 2'd2;
  logic          bss = 1'b0;
  logic          brs = 1'b0;
  logic          lap_rd = 1'b0;
  logic          running;
  logic [31:0]   data_s;
  logic [31:0]   lap_data;
  logic          lap_valid;
  logic [CW-1:0] lap_count;
  logic          lap_overflow;
  logic          overflow;

  lap_stopwatch #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX),
    .LAP_DEPTH(LAP_DEPTH), .MODE_ID(MODE_ID)
  ) dut (
    .clock(clock), .reset(reset), .rezhim(rezhim),
    .button_start_stop(bss), .button_reset(brs), .lap_rd(lap_rd),
    .running(running), .data_s(data_s), .lap_data(lap_data),
    .lap_valid(lap_valid), .lap_count(lap_count),
    .lap_overflow(lap_overflow), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        run;
    logic [31:0] d;
    logic [31:0] ld;
    logic        lv;
    logic [7:0]  lc;
    logic        lov;
    logic        ov;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  // reference model: elapsed time as one integer of hundredths
  int          m_tot, m_presc;
  bit          m_run, m_ov, m_lov;
  logic [31:0] m_laps[$];
  bit          sa, sb, sc, ra, rb, rc;
  bit          ssp, rsp, run0, ovp, rd;
  logic [31:0] pre;

  function automatic logic [31:0] conv(input int t);
    int cs, s, m, h;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = (t / 6000) % 60;
    h  = t / 360000;
    return {8'(h), 8'(m), 8'(s), 8'(cs)};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_tot = 0; m_presc = 0;
      m_run = 0; m_ov = 0; m_lov = 0;
      m_laps.delete();
      sa = 0; sb = 0; sc = 0;
      ra = 0; rb = 0; rc = 0;
    end else begin
      // a press takes effect on the 3rd edge counting the first one
      // that sees the raw level high
      ssp = sb && !sc && (rezhim == 2'(MODE_ID));
      rsp = rb && !rc && (rezhim == 2'(MODE_ID));
      sc = sb; sb = sa; sa = bss;
      rc = rb; rb = ra; ra = brs;
      run0 = m_run;
      ovp  = m_ov;
      rd   = lap_rd;
      if (rsp && !run0) begin
        m_tot = 0; m_presc = 0;
        m_ov = 0; m_lov = 0;
        m_laps.delete();
        m_run = ssp && !ovp;
      end else begin
        pre = conv(m_tot);
        if (run0) begin
          if (m_presc == DIV - 1) begin
            m_presc = 0;
            if (m_tot == MAXT) begin
              m_ov = 1; m_run = 0;
            end else begin
              m_tot++;
            end
          end else begin
            m_presc++;
          end
        end
        if (rd && m_laps.size() > 0)
          void'(m_laps.pop_front());
        if (rsp && run0) begin
          if (m_laps.size() < LAP_DEPTH) m_laps.push_back(pre);
          else m_lov = 1;
        end
        if (ssp) begin
          if (run0) m_run = 0;
          else if (!ovp) m_run = 1;
        end
      end
    end
  end

  task automatic expect_model(input string nm);
    snap_t s;
    s.run = m_run;
    s.d   = conv(m_tot);
    s.ld  = (m_laps.size() > 0) ? m_laps[0] : 32'd0;
    s.lv  = (m_laps.size() > 0);
    s.lc  = 8'(m_laps.size());
    s.lov = m_lov;
    s.ov  = m_ov;
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic expect_const(input string nm, input snap_t s);
    exp_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic cmp(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, want);
    end
  endtask

  // monitor: drains every pending expectation away from the clock edge
  always @(negedge clock) begin
    snap_t e;
    string nm;
    #1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "running", 32'(running), 32'(e.run));
      cmp(nm, "data_s", data_s, e.d);
      cmp(nm, "lap_data", lap_data, e.ld);
      cmp(nm, "lap_valid", 32'(lap_valid), 32'(e.lv));
      cmp(nm, "lap_count", 32'(lap_count), 32'(e.lc));
      cmp(nm, "lap_overflow", 32'(lap_overflow), 32'(e.lov));
      cmp(nm, "overflow", 32'(overflow), 32'(e.ov));
    end
  end

  task automatic press(input bit s, input bit r);
    @(negedge clock);
    bss = s; brs = r;
    repeat (4) @(negedge clock);
    bss = 0; brs = 0;
    @(negedge clock);
  endtask

  // lap press with lap_rd landing on the same edge as the pulse
  task automatic press_rs_rd();
    @(negedge clock); brs = 1;
    @(negedge clock);
    @(negedge clock); lap_rd = 1;
    @(negedge clock); lap_rd = 0;
    @(negedge clock); brs = 0;
    @(negedge clock);
  endtask

  task automatic preload(input int h, input int m, input int s, input int c);
    @(negedge clock);
    force dut.hour_q = 8'(h);
    force dut.min_q  = 8'(m);
    force dut.sec_q  = 8'(s);
    force dut.csec_q = 8'(c);
    #1;
    release dut.hour_q;
    release dut.min_q;
    release dut.sec_q;
    release dut.csec_q;
    m_tot = ((h * 60 + m) * 60 + s) * 100 + c;
  endtask

  snap_t zero_s, sat_s;

  initial begin
    zero_s = '0;
    sat_s  = '0;
    sat_s.d  = 32'h013B3B63;
    sat_s.ov = 1'b1;

    repeat (3) @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    expect_model("idle");

    // reset mid-run must clear before the next clock edge
    press(1, 0);
    repeat (200) @(negedge clock);
    expect_model("prerun");
    @(posedge clock);
    #2 reset = 0;
    #1 expect_const("async_rst", zero_s);
    @(negedge clock);
    reset = 1;
    repeat (3) @(negedge clock);
    expect_const("post_rst", zero_s);

    // one second of counting
    press(1, 0);
    repeat (995) @(negedge clock);
    expect_model("run_1s");

    // laps: fill, push+pop on full, then drop
    press(1, 0);
    press(0, 1);
    expect_const("clr_a", zero_s);
    press(1, 0);
    repeat (362) @(negedge clock);
    press(0, 1);
    expect_model("lap1");
    repeat (40) @(negedge clock);
    press(0, 1);
    expect_model("lap_full");
    repeat (20) @(negedge clock);
    press_rs_rd();
    expect_model("lap_pushpop");
    press(0, 1);
    expect_model("lap_drop");
    @(negedge clock); lap_rd = 1;
    @(negedge clock); lap_rd = 0;
    expect_model("lap_pop");

    // stop/freeze/resume, then clear
    press(1, 0);
    expect_model("stop");
    repeat (500) @(negedge clock);
    expect_model("frozen");
    press(1, 0);
    repeat (57) @(negedge clock);
    expect_model("resume");
    press(1, 0);
    press(0, 1);
    repeat (2) @(negedge clock);
    expect_const("clr_b", zero_s);

    // hour carry, then saturation at the top value
    preload(0, 59, 59, 98);
    press(1, 0);
    repeat (40) @(negedge clock);
    expect_model("hour_carry");
    press(1, 0);
    press(0, 1);
    preload(1, 59, 59, 90);
    press(1, 0);
    repeat (150) @(negedge clock);
    expect_const("saturate", sat_s);
    expect_model("saturate_m");
    press(1, 0);
    repeat (20) @(negedge clock);
    expect_const("start_locked", sat_s);

    // other mode ignores buttons but keeps counting
    press(0, 1);
    press(1, 0);
    repeat (30) @(negedge clock);
    rezhim = 2'd1;
    press(1, 1);
    repeat (30) @(negedge clock);
    expect_model("mode_other");
    rezhim = 2'd2;
    press(1, 0);
    repeat (5) @(negedge clock);
    expect_model("stop2");
    press(1, 1);
    repeat (30) @(negedge clock);
    expect_model("both_stopped");

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) bss = ~bss;
      if ($urandom_range(0, 29) == 0) brs = ~brs;
      lap_rd = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0)
        rezhim = 2'($urandom_range(1, 2));
      if (i % 5 == 0) expect_model("rand");
    end
    @(negedge clock);
    bss = 0; brs = 0; lap_rd = 0;
    repeat (5) @(negedge clock);
    expect_model("final");
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
